// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream path: state-word type, counter FSM
// states and the state-word slots that the block counter occupies.
package chacha_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXHAUST = 2'd2
  } ctr_state_t;

  localparam int CTR_WORD_IDX_LO = 12;
  localparam int CTR_WORD_IDX_HI = 13;
endpackage

// File: rtl/chacha_ctr_core.sv
// CTR_W-bit block counter register: seed load, modulo increment and an
// all-ones detect used by the sequencer for wrap/exhaust decisions.
module chacha_ctr_core #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [CTR_W-1:0] i_seed,
  output logic [CTR_W-1:0] o_ctr,
  output logic             o_all_ones
);
  logic [CTR_W-1:0] r_ctr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctr <= '0;
    end else if (i_load) begin
      r_ctr <= i_seed;
    end else if (i_inc) begin
      r_ctr <= r_ctr + CTR_W'(1);
    end
  end

  assign o_ctr      = r_ctr;
  assign o_all_ones = &r_ctr;
endmodule

// File: rtl/chacha_ctr_sequencer.sv
// ChaCha20 block-counter sequencer: offers counter values to the core over a
// valid/ready handshake with seedable start, wrap/exhaust policy and budget.
module chacha_ctr_sequencer
  import chacha_pkg::*;
#(
  parameter int          CTR_W      = 32,
  parameter bit          WRAP_EN    = 1'b0,
  parameter int unsigned MAX_BLOCKS = 0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CTR_W-1:0] ctr_seed,
  output logic             ctr_valid,
  input  logic             ctr_ready,
  output logic [31:0]      ctr_word0,
  output logic [31:0]      ctr_word1,
  output logic             busy,
  output logic             done,
  output logic             wrapped,
  output logic             exhausted,
  output logic [CNT_W-1:0] blocks_issued
);
  ctr_state_t       r_state, w_state_nxt;
  logic [CTR_W-1:0] w_ctr;
  logic [CNT_W-1:0] r_blocks, w_blocks_inc;
  logic             w_all_ones, w_hs, w_start, w_issue, w_inc;
  logic             w_exh_now, w_wrap_now, w_budget_hit;
  logic             r_exhausted, r_done, r_wrapped;
  word_t            w_word1;

  // A start that coincides with abort is ignored; a handshake during start is discarded,
  // but a handshake during abort still counts because the core consumed it.
  assign w_hs         = ctr_valid && ctr_ready;
  assign w_start      = start && !abort;
  assign w_issue      = w_hs && !w_start;
  assign w_exh_now    = w_issue && w_all_ones && !WRAP_EN;
  assign w_wrap_now   = w_issue && w_all_ones && WRAP_EN;
  assign w_inc        = w_issue && !w_exh_now;
  assign w_blocks_inc = (&r_blocks) ? r_blocks : r_blocks + CNT_W'(1);
  assign w_budget_hit = w_issue && (MAX_BLOCKS != 0) &&
                        (64'(w_blocks_inc) == 64'(MAX_BLOCKS));

  chacha_ctr_core #(.CTR_W(CTR_W)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_inc      (w_inc),
    .i_seed     (ctr_seed),
    .o_ctr      (w_ctr),
    .o_all_ones (w_all_ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort)             w_state_nxt = IDLE;
    else if (start)        w_state_nxt = RUN;
    else if (w_exh_now)    w_state_nxt = EXHAUST;
    else if (w_budget_hit) w_state_nxt = IDLE;
  end

  always_comb begin
    ctr_valid = (r_state == RUN);
    busy      = (r_state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blocks    <= '0;
      r_exhausted <= 1'b0;
      r_done      <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_done    <= w_budget_hit;
      r_wrapped <= w_wrap_now;
      if (w_start) begin
        r_blocks    <= '0;
        r_exhausted <= 1'b0;
      end else begin
        if (w_issue)   r_blocks    <= w_blocks_inc;
        if (w_exh_now) r_exhausted <= 1'b1;
      end
    end
  end

  generate
    if (CTR_W == 64) begin : g_ctr64
      assign w_word1 = w_ctr[63:32];
    end else begin : g_ctr32
      assign w_word1 = '0;
    end
  endgenerate

  assign ctr_word0     = w_ctr[31:0];
  assign ctr_word1     = w_word1;
  assign done          = r_done;
  assign wrapped       = r_wrapped;
  assign exhausted     = r_exhausted;
  assign blocks_issued = r_blocks;
endmodule
